// File: rtl/size_measure.sv
// Beat-stream packet size measurement with a valid/ack result handshake.
// Optional SIZE_MEASURE_START_EN adds a data_start first-beat marker.
module size_measure #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             data_valid,
  input  logic             data_last,
`ifdef SIZE_MEASURE_START_EN
  input  logic             data_start,
`endif
  output logic             data_ready,
  output logic [WIDTH-1:0] size,
  output logic             size_valid,
  input  logic             size_ack,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] size_q, size_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;

  logic             accept;
  logic             is_start;
  logic             restart;
  logic             at_max;
  logic [WIDTH-1:0] count_inc;

  assign data_ready = (state_q != HOLD);
  assign size_valid = (state_q == HOLD);
  assign busy       = (state_q == COUNT);
  assign size       = size_q;
  assign overflow   = ovf_q;

  assign accept    = data_valid && data_ready;
  assign at_max    = (count_q == MAX);
  assign count_inc = at_max ? MAX : count_q + ONE;

`ifdef SIZE_MEASURE_START_EN
  assign is_start = data_start;
  assign restart  = data_start;
`else
  assign is_start = 1'b1;
  assign restart  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    size_d   = size_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    unique case (state_q)
      IDLE: begin
        if (accept && is_start) begin
          if (data_last) begin
            size_d  = ONE;
            ovf_d   = 1'b0;
            state_d = HOLD;
          end else begin
            count_d  = ONE;
            sticky_d = 1'b0;
            state_d  = COUNT;
          end
        end
      end
      COUNT: begin
        if (accept) begin
          if (restart) begin
            sticky_d = 1'b0;
            if (data_last) begin
              size_d  = ONE;
              ovf_d   = 1'b0;
              count_d = '0;
              state_d = HOLD;
            end else begin
              count_d = ONE;
            end
          end else if (data_last) begin
            // the final increment may itself be the one that saturates
            size_d   = count_inc;
            ovf_d    = sticky_q | at_max;
            count_d  = '0;
            sticky_d = 1'b0;
            state_d  = HOLD;
          end else begin
            count_d = count_inc;
            if (at_max) sticky_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (size_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      size_q   <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      size_q   <= size_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_size_measure.sv
// Directed self-checking bench for size_measure (WIDTH=32 and WIDTH=3).
// Start-marker scenarios run when SIZE_MEASURE_START_EN is defined.
module tb_size_measure;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;

  logic        data_valid = 1'b0;
  logic        data_last  = 1'b0;
  logic        data_start = 1'b0;
  logic        size_ack   = 1'b0;
  logic        data_ready;
  logic [31:0] size;
  logic        size_valid;
  logic        overflow;
  logic        busy;

  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        s_start = 1'b0;
  logic        s_ack   = 1'b0;
  logic        s_ready;
  logic [2:0]  s_size;
  logic        s_size_valid;
  logic        s_overflow;
  logic        s_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  size_measure #(.WIDTH(32)) u_dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .data_last  (data_last),
`ifdef SIZE_MEASURE_START_EN
    .data_start (data_start),
`endif
    .data_ready (data_ready),
    .size       (size),
    .size_valid (size_valid),
    .size_ack   (size_ack),
    .overflow   (overflow),
    .busy       (busy)
  );

  size_measure #(.WIDTH(3)) u_small (
    .clock      (clock),
    .rst_n      (rst_n),
    .data_valid (s_valid),
    .data_last  (s_last),
`ifdef SIZE_MEASURE_START_EN
    .data_start (s_start),
`endif
    .data_ready (s_ready),
    .size       (s_size),
    .size_valid (s_size_valid),
    .size_ack   (s_ack),
    .overflow   (s_overflow),
    .busy       (s_busy)
  );

  task automatic beat(input logic st, input logic last, input int gap);
    repeat (gap) @(posedge clock);
    if (gap > 0) #1;
    data_valid = 1'b1;
    data_last  = last;
    data_start = st;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    data_last  = 1'b0;
    data_start = 1'b0;
  endtask

  task automatic s_beat(input logic st, input logic last);
    s_valid = 1'b1;
    s_last  = last;
    s_start = st;
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic ack();
    size_ack = 1'b1;
    @(posedge clock);
    #1;
    size_ack = 1'b0;
  endtask

  task automatic s_ack_pulse();
    s_ack = 1'b1;
    @(posedge clock);
    #1;
    s_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({size_valid, busy, overflow, data_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0001",
               {size_valid, busy, overflow, data_ready});
    end
    checks++;
    if (size !== 32'd0) begin
      failures++;
      $display("FAIL reset_size got=%0d exp=0", size);
    end
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    beat(1'b1, 1'b0, 0);
    checks++;
    if (busy !== 1'b1 || size_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy got=%b%b exp=10", busy, size_valid);
    end
    for (int i = 2; i <= 5; i++) beat(1'b0, i == 5, 0);
    checks++;
    if (size_valid !== 1'b1 || size !== 32'd5) begin
      failures++;
      $display("FAIL basic_size got=%0d v=%b exp=5 v=1", size, size_valid);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (data_ready !== 1'b0 || size_valid !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL basic_hold got=r%b v%b b%b exp=r0 v1 b0",
                 data_ready, size_valid, busy);
      end
      @(posedge clock);
      #1;
    end
    ack();
    checks++;
    if (size_valid !== 1'b0 || data_ready !== 1'b1 || size !== 32'd5) begin
      failures++;
      $display("FAIL basic_ack got=v%b r%b s%0d exp=v0 r1 s5",
               size_valid, data_ready, size);
    end
  endtask

  task automatic test_single_and_gaps();
    beat(1'b1, 1'b1, 0);
    checks++;
    if (size_valid !== 1'b1 || size !== 32'd1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL single got=%0d v=%b o=%b exp=1 v=1 o=0",
               size, size_valid, overflow);
    end
    ack();
    beat(1'b1, 1'b0, 0);
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1 || data_ready !== 1'b1) begin
      failures++;
      $display("FAIL gap_busy got=b%b r%b exp=b1 r1", busy, data_ready);
    end
    beat(1'b0, 1'b0, 1);
    beat(1'b0, 1'b1, 2);
    checks++;
    if (size_valid !== 1'b1 || size !== 32'd3) begin
      failures++;
      $display("FAIL gaps_size got=%0d v=%b exp=3 v=1", size, size_valid);
    end
    ack();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 10; i++) s_beat(i == 1, i == 10);
    checks++;
    if (s_size_valid !== 1'b1 || s_size !== 3'd7 || s_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sat got=%0d v=%b o=%b exp=7 v=1 o=1",
               s_size, s_size_valid, s_overflow);
    end
    s_ack_pulse();
    s_beat(1'b1, 1'b0);
    s_beat(1'b0, 1'b1);
    checks++;
    if (s_size_valid !== 1'b1 || s_size !== 3'd2 || s_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%0d v=%b o=%b exp=2 v=1 o=0",
               s_size, s_size_valid, s_overflow);
    end
    s_ack_pulse();
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) beat(i == 1, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({size_valid, busy, overflow, data_ready} !== 4'b0001
        || size !== 32'd0) begin
      failures++;
      $display("FAIL async_rst got=%b s=%0d exp=0001 s=0",
               {size_valid, busy, overflow, data_ready}, size);
    end
    @(posedge clock);
    #2;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (size_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_post got=v%b b%b exp=v0 b0", size_valid, busy);
    end
    for (int i = 1; i <= 4; i++) beat(i == 1, i == 4, 0);
    checks++;
    if (size_valid !== 1'b1 || size !== 32'd4) begin
      failures++;
      $display("FAIL async_next got=%0d v=%b exp=4 v=1", size, size_valid);
    end
    ack();
  endtask

`ifdef SIZE_MEASURE_START_EN
  task automatic test_start();
    beat(1'b0, 1'b0, 0);
    beat(1'b0, 1'b0, 0);
    checks++;
    if (busy !== 1'b0 || size_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_discard got=b%b v%b exp=b0 v0", busy, size_valid);
    end
    for (int i = 1; i <= 4; i++) beat(i == 1, i == 4, 0);
    checks++;
    if (size_valid !== 1'b1 || size !== 32'd4) begin
      failures++;
      $display("FAIL start_pkt got=%0d v=%b exp=4 v=1", size, size_valid);
    end
    ack();
    for (int i = 1; i <= 5; i++) beat(i == 1 || i == 3, i == 5, 0);
    checks++;
    if (size_valid !== 1'b1 || size !== 32'd3) begin
      failures++;
      $display("FAIL start_restart got=%0d v=%b exp=3 v=1", size, size_valid);
    end
    ack();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_single_and_gaps();
    test_overflow();
    test_async_reset();
`ifdef SIZE_MEASURE_START_EN
    test_start();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/size_measure.md
Name: size_measure

Overview:
- Stream-side counterpart to size_count: size_count is given a size and flags the final beat.
- This block does the opposite. It watches a beat stream, counts the beats of each packet up to and including the beat marked last, and reports the packet size through a valid/ack handshake.
- It sits on the receive side of the packet interface. It feeds the size to whatever later drives size_count for retransmission.

Parameters:
- WIDTH, 32, width of the size counter and of the size output.

Ports:
- clock  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- data_valid  input  1  a beat is present this cycle.
- data_last  input  1  the present beat is the final beat of its packet; only meaningful with data_valid.
- data_ready  output  1  the block can accept a beat; a beat is accepted when data_valid && data_ready.
- size  output  WIDTH  measured beat count of the completed packet.
- size_valid  output  1  size and overflow hold a completed result.
- size_ack  input  1  the consumer takes the result; only meaningful while size_valid=1.
- overflow  output  1  the packet beat count exceeded 2^WIDTH-1; qualified by size_valid.
- busy  output  1  a packet is in progress (state COUNT).

Behaviour:
Clock and reset
- Single clock domain; all state updates on the rising edge of clock.
- rst_n low asynchronously forces: state IDLE, count=0, size=0, size_valid=0, overflow=0, busy=0.
- data_ready is 1 while rst_n is low; it is decoded from state, so it is 1 in IDLE.
- Reset mid-packet or mid-report discards everything; no partial result is ever reported.

States
- IDLE: data_ready=1, busy=0, size_valid=0.
  - Accepted beat with data_last=1: size<=1, overflow<=0, go to HOLD (single-beat packet).
  - Accepted beat with data_last=0: count<=1, go to COUNT.
  - No accepted beat: stay in IDLE.
- COUNT: data_ready=1, busy=1.
  - Accepted beat with data_last=0: count<=count+1, saturating at 2^WIDTH-1. An attempted increment past the maximum sets the internal sticky overflow flag.
  - Accepted beat with data_last=1: size<=count+1 (saturated) and overflow<=sticky. This includes the case where this final increment itself would saturate. Then count<=0 and go to HOLD.
  - Cycles with data_valid=0 are idle gaps: count is unchanged and the state is unchanged.
- HOLD: size_valid=1, data_ready=0, busy=0.
  - size and overflow stay stable until the cycle after size_ack.
  - size_ack=1: go to IDLE and clear size_valid.
  - size is not cleared on ack; it keeps its last value.

Timing and arithmetic
- Latency: size_valid rises on the clock edge that accepts the last beat, so it is visible in the next cycle.
- Minimum spacing: a new packet may begin the cycle after the ack edge. data_ready is never combinationally tied to size_ack.
- Arithmetic is unsigned, modulo-free: size never wraps, it saturates.
- size_ack while size_valid=0 is ignored.
- data_last while data_valid=0 is ignored.

Optional Feature:
Macro: SIZE_MEASURE_START_EN.

With the macro defined:
- An extra port data_start (input, 1 bit) is present; it marks the first beat of a packet.
- In IDLE, an accepted beat with data_start=0 is consumed and discarded; the state stays IDLE.
- In COUNT, an accepted beat with data_start=1 abandons the current packet and restarts it: count<=1 and the sticky overflow flag is cleared.
  - If that beat also has data_last=1, report size=1.
- A beat with data_start=1 and data_last=1 in IDLE is a single-beat packet.

Without the macro:
- The data_start port does not exist.
- The first accepted beat in IDLE always starts a packet.

Test Plan:
1. Reset rst_n=0 for 2 cycles, then release. Drive 5 beats back-to-back with last on beat 5, and hold size_ack=0 for 3 cycles. Required: size=5, size_valid=1 from the cycle after beat 5, data_ready=0 throughout HOLD. Then pulse size_ack=1 for 1 cycle: size_valid=0 and data_ready=1 in the next cycle.
2. Single beat with data_last=1 from IDLE -> size=1, overflow=0. Then a 3-beat packet with data_valid gaps of 2 cycles between beats -> size=3.
3. Override to WIDTH=3 and drive a 10-beat packet -> size=7, overflow=1. The next 2-beat packet -> size=2, overflow=0.
4. Assert rst_n=0 asynchronously (between clock edges) after beat 3 of a 6-beat packet, then release. Required: all outputs return to their reset values immediately, with no size_valid. A following 4-beat packet reports size=4.
5. With SIZE_MEASURE_START_EN defined:
   - 2 beats with start=0 in IDLE, then a 4-beat packet with start on beat 1 -> size=4.
   - Start re-asserted on beat 3 of a 5-beat run -> size=3.
